// File: rtl/pipeline_reg_memwb_skid.sv
// MEM/WB pipeline register with a 2-entry skid buffer.
// Writeback data (ALU result or aligned/extended load data) is formed at the
// input and stored. A combinational lookup port lets the forwarding unit read
// results that are still held here and have not yet committed.
module pipeline_reg_memwb_skid #(
   parameter int DATA_WIDTH       = 32,
   parameter int REG_ADDR_W       = 5,
   parameter bit ZERO_REG_DISCARD = 1'b1
) (
   input  logic                              clk,
   input  logic                              rst,
   input  logic                              flush,
   input  logic                              in_valid,
   output logic                              in_ready,
   input  logic [REG_ADDR_W-1:0]             in_rd,
   input  logic                              in_reg_we,
   input  logic                              in_sel_alu,
   input  logic [DATA_WIDTH-1:0]             in_alu_result,
   input  logic [DATA_WIDTH-1:0]             in_mem_result,
   input  logic [1:0]                        in_mem_size,
   input  logic                              in_mem_unsigned,
   input  logic [$clog2(DATA_WIDTH/8)-1:0]   in_byte_off,
   output logic                              out_valid,
   input  logic                              out_ready,
   output logic [REG_ADDR_W-1:0]             out_rd,
   output logic                              out_we,
   output logic [DATA_WIDTH-1:0]             out_data,
   input  logic [REG_ADDR_W-1:0]             lookup_rd,
   output logic                              lookup_hit,
   output logic [DATA_WIDTH-1:0]             lookup_data
);

   localparam int OFF_W = $clog2(DATA_WIDTH/8);

   // Align the load lane to its natural size, then sign/zero-extend it.
   // The extension is done with a mask so a full-width access needs no
   // zero-width replication.
   function automatic logic [DATA_WIDTH-1:0] load_extract(
      input logic [DATA_WIDTH-1:0] mem,
      input logic [1:0]            size,
      input logic                  uns,
      input logic [OFF_W-1:0]      off
   );
      logic [OFF_W-1:0]      align_mask;
      logic [OFF_W-1:0]      off_al;
      logic [DATA_WIDTH-1:0] shifted;
      logic [DATA_WIDTH-1:0] ones;
      logic [DATA_WIDTH-1:0] mask;
      logic [DATA_WIDTH-1:0] top;
      logic                  sgn;
      int                    nbits;
      ones = '1;
      case (size)
         2'd0:    begin align_mask = '0;         nbits = 8;          end
         2'd1:    begin align_mask = OFF_W'(1);  nbits = 16;         end
         2'd2:    begin align_mask = OFF_W'(3);  nbits = 32;         end
         default: begin align_mask = '1;         nbits = DATA_WIDTH; end
      endcase
      off_al  = off & ~align_mask;
      shifted = mem >> {off_al, 3'b000};
      mask    = ones >> (DATA_WIDTH - nbits);
      top     = mask ^ (mask >> 1);
      sgn     = !uns && (|(shifted & top));
      return (shifted & mask) | (sgn ? ~mask : '0);
   endfunction

   logic                  main_vld_q, main_vld_d;
   logic [REG_ADDR_W-1:0] main_rd_q,  main_rd_d;
   logic                  main_we_q,  main_we_d;
   logic [DATA_WIDTH-1:0] main_data_q, main_data_d;
   logic                  skid_vld_q, skid_vld_d;
   logic [REG_ADDR_W-1:0] skid_rd_q,  skid_rd_d;
   logic                  skid_we_q,  skid_we_d;
   logic [DATA_WIDTH-1:0] skid_data_q, skid_data_d;

   logic                  accept;
   logic                  commit;
   logic                  in_we_w;
   logic [DATA_WIDTH-1:0] in_data_w;

   // in_ready depends only on held state, so there is no path from out_ready.
   assign in_ready  = !skid_vld_q;
   assign accept    = in_valid && in_ready;
   assign commit    = main_vld_q && out_ready;
   assign in_we_w   = in_reg_we && !(ZERO_REG_DISCARD && (in_rd == '0));
   assign in_data_w = in_sel_alu ? in_alu_result
                                 : load_extract(in_mem_result, in_mem_size,
                                                in_mem_unsigned, in_byte_off);

   // Next-state for main/skid: flush wins, then skid refill, then direct load.
   always_comb begin
      main_vld_d  = main_vld_q;
      main_rd_d   = main_rd_q;
      main_we_d   = main_we_q;
      main_data_d = main_data_q;
      skid_vld_d  = skid_vld_q;
      skid_rd_d   = skid_rd_q;
      skid_we_d   = skid_we_q;
      skid_data_d = skid_data_q;
      if (flush) begin
         main_vld_d = 1'b0;
         skid_vld_d = 1'b0;
      end else if (commit && skid_vld_q) begin
         // in_ready is low here, so no accept competes with the refill.
         main_vld_d  = 1'b1;
         main_rd_d   = skid_rd_q;
         main_we_d   = skid_we_q;
         main_data_d = skid_data_q;
         skid_vld_d  = 1'b0;
      end else if (!main_vld_q || commit) begin
         main_vld_d = accept;
         if (accept) begin
            main_rd_d   = in_rd;
            main_we_d   = in_we_w;
            main_data_d = in_data_w;
         end
      end else if (accept) begin
         skid_vld_d  = 1'b1;
         skid_rd_d   = in_rd;
         skid_we_d   = in_we_w;
         skid_data_d = in_data_w;
      end
   end

   // State registers; reset clears every entry without waiting for clk.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         main_vld_q  <= 1'b0;
         main_rd_q   <= '0;
         main_we_q   <= 1'b0;
         main_data_q <= '0;
         skid_vld_q  <= 1'b0;
         skid_rd_q   <= '0;
         skid_we_q   <= 1'b0;
         skid_data_q <= '0;
      end else begin
         main_vld_q  <= main_vld_d;
         main_rd_q   <= main_rd_d;
         main_we_q   <= main_we_d;
         main_data_q <= main_data_d;
         skid_vld_q  <= skid_vld_d;
         skid_rd_q   <= skid_rd_d;
         skid_we_q   <= skid_we_d;
         skid_data_q <= skid_data_d;
      end
   end

   assign out_valid = main_vld_q;
   assign out_rd    = main_rd_q;
   assign out_we    = main_we_q;
   assign out_data  = main_data_q;

   // Forwarding lookup: the skid entry is younger, so it takes priority.
   always_comb begin
      logic lk_ok;
      lookup_hit  = 1'b0;
      lookup_data = '0;
      lk_ok       = !(ZERO_REG_DISCARD && (lookup_rd == '0));
      if (lk_ok && skid_vld_q && skid_we_q && (skid_rd_q == lookup_rd)) begin
         lookup_hit  = 1'b1;
         lookup_data = skid_data_q;
      end else if (lk_ok && main_vld_q && main_we_q && (main_rd_q == lookup_rd)) begin
         lookup_hit  = 1'b1;
         lookup_data = main_data_q;
      end
   end

endmodule

// File: tb/tb_pipeline_reg_memwb_skid.sv
// Bench for pipeline_reg_memwb_skid (DATA_WIDTH=32): scoreboard of accepted
// entries compared against commits, plus per-scenario direct checks.
module tb_pipeline_reg_memwb_skid;

   localparam int DW = 32;
   localparam int AW = 5;

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic          flush = 1'b0;
   logic          in_valid = 1'b0;
   logic          in_ready;
   logic [AW-1:0] in_rd = '0;
   logic          in_reg_we = 1'b0;
   logic          in_sel_alu = 1'b1;
   logic [DW-1:0] in_alu_result = '0;
   logic [DW-1:0] in_mem_result = '0;
   logic [1:0]    in_mem_size = 2'd0;
   logic          in_mem_unsigned = 1'b0;
   logic [1:0]    in_byte_off = 2'd0;
   logic          out_valid;
   logic          out_ready = 1'b1;
   logic [AW-1:0] out_rd;
   logic          out_we;
   logic [DW-1:0] out_data;
   logic [AW-1:0] lookup_rd = '0;
   logic          lookup_hit;
   logic [DW-1:0] lookup_data;

   int checks = 0;
   int passes = 0;

   typedef struct packed {
      logic [AW-1:0] rd;
      logic          we;
      logic [DW-1:0] data;
   } entry_t;

   entry_t sb[$];

   pipeline_reg_memwb_skid #(
      .DATA_WIDTH(DW), .REG_ADDR_W(AW), .ZERO_REG_DISCARD(1'b1)
   ) dut (
      .clk(clk), .rst(rst), .flush(flush),
      .in_valid(in_valid), .in_ready(in_ready), .in_rd(in_rd),
      .in_reg_we(in_reg_we), .in_sel_alu(in_sel_alu),
      .in_alu_result(in_alu_result), .in_mem_result(in_mem_result),
      .in_mem_size(in_mem_size), .in_mem_unsigned(in_mem_unsigned),
      .in_byte_off(in_byte_off),
      .out_valid(out_valid), .out_ready(out_ready), .out_rd(out_rd),
      .out_we(out_we), .out_data(out_data),
      .lookup_rd(lookup_rd), .lookup_hit(lookup_hit), .lookup_data(lookup_data)
   );

   always #5 clk = ~clk;

   // Reference writeback value for a 32-bit datapath.
   function automatic logic [DW-1:0] model_data(
      input logic sel, input logic [DW-1:0] alu, input logic [DW-1:0] mem,
      input logic [1:0] size, input logic uns, input logic [1:0] off);
      logic [7:0]  b;
      logic [15:0] h;
      if (sel) return alu;
      case (size)
         2'd0: begin
            b = mem[8*off +: 8];
            return uns ? {24'h0, b} : {{24{b[7]}}, b};
         end
         2'd1: begin
            h = off[1] ? mem[31:16] : mem[15:0];
            return uns ? {16'h0, h} : {{16{h[15]}}, h};
         end
         default: return mem;
      endcase
   endfunction

   // One clock: scoreboard bookkeeping at the falling edge, then advance to
   // just after the next rising edge.
   task automatic step();
      entry_t e;
      @(negedge clk);
      if (rst) begin
         sb.delete();
      end else begin
         if (out_valid && out_ready) begin
            checks++;
            if (sb.size() == 0) begin
               $display("FAIL sb_commit: unexpected commit rd=%0d data=%h, required no commit", out_rd, out_data);
            end else begin
               e = sb.pop_front();
               if ({out_rd, out_we, out_data} !== {e.rd, e.we, e.data})
                  $display("FAIL sb_commit: got rd=%0d we=%0b data=%h, required rd=%0d we=%0b data=%h",
                           out_rd, out_we, out_data, e.rd, e.we, e.data);
               else passes++;
            end
         end
         if (flush) begin
            sb.delete();
         end else if (in_valid && in_ready) begin
            e.rd   = in_rd;
            e.we   = in_reg_we && (in_rd != '0);
            e.data = model_data(in_sel_alu, in_alu_result, in_mem_result,
                                in_mem_size, in_mem_unsigned, in_byte_off);
            sb.push_back(e);
         end
      end
      @(posedge clk);
      #1;
   endtask

   task automatic set_alu(input logic [AW-1:0] rd, input logic [DW-1:0] v);
      in_valid = 1'b1; in_rd = rd; in_reg_we = 1'b1; in_sel_alu = 1'b1; in_alu_result = v;
   endtask

   task automatic test_reset();
      #2;
      checks++;
      if ({out_valid, out_rd, out_we, out_data, in_ready, lookup_hit} !== {1'b0, 5'd0, 1'b0, 32'd0, 1'b1, 1'b0})
         $display("FAIL reset: got v=%0b rd=%0d we=%0b d=%h rdy=%0b hit=%0b, required 0 0 0 0 1 0",
                  out_valid, out_rd, out_we, out_data, in_ready, lookup_hit);
      else passes++;
      step();
      rst = 1'b0;
      step();
   endtask

   task automatic test_back_to_back();
      out_ready = 1'b1;
      for (int i = 1; i <= 4; i++) begin
         set_alu(AW'(i), DW'(32'h11 * i));
         step();
         checks++;
         if (out_valid !== 1'b1 || out_rd !== AW'(i) || in_ready !== 1'b1)
            $display("FAIL b2b_latency: got v=%0b rd=%0d rdy=%0b, required v=1 rd=%0d rdy=1",
                     out_valid, out_rd, in_ready, i);
         else passes++;
      end
      in_valid = 1'b0;
      step();
      checks++;
      if (out_valid !== 1'b0) $display("FAIL b2b_drain: got out_valid=%0b, required 0", out_valid);
      else passes++;
   endtask

   task automatic test_load();
      logic [1:0]    sz[8]  = '{2'd0, 2'd0, 2'd0, 2'd1, 2'd1, 2'd1, 2'd0, 2'd2};
      logic          un[8]  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0};
      logic [1:0]    of[8]  = '{2'd1, 2'd2, 2'd3, 2'd2, 2'd3, 2'd2, 2'd3, 2'd1};
      logic [DW-1:0] ex[8]  = '{32'h0000007F, 32'hFFFFFFFF, 32'hFFFFFF80, 32'hFFFF80FF,
                                32'hFFFF80FF, 32'h000080FF, 32'h00000080, 32'h80FF7F01};
      out_ready = 1'b1;
      in_mem_result = 32'h80FF7F01;
      for (int i = 0; i < 8; i++) begin
         in_valid = 1'b1; in_rd = AW'(10 + i); in_reg_we = 1'b1; in_sel_alu = 1'b0;
         in_mem_size = sz[i]; in_mem_unsigned = un[i]; in_byte_off = of[i];
         step();
         checks++;
         if (out_data !== ex[i])
            $display("FAIL load_%0d: got %h, required %h", i, out_data, ex[i]);
         else passes++;
      end
      in_valid = 1'b0; in_sel_alu = 1'b1;
      step();
   endtask

   task automatic test_stall();
      out_ready = 1'b0;
      set_alu(5'd5, 32'hA5);
      step();
      checks++;
      if (out_valid !== 1'b1 || out_rd !== 5'd5 || in_ready !== 1'b1)
         $display("FAIL stall_a: got v=%0b rd=%0d rdy=%0b, required 1 5 1", out_valid, out_rd, in_ready);
      else passes++;
      set_alu(5'd6, 32'hB6);
      step();
      checks++;
      if (out_rd !== 5'd5 || out_data !== 32'hA5 || in_ready !== 1'b0)
         $display("FAIL stall_b: got rd=%0d d=%h rdy=%0b, required 5 a5 0", out_rd, out_data, in_ready);
      else passes++;
      set_alu(5'd9, 32'hDEAD);   // offered while full: must not be taken
      step();
      checks++;
      if (out_rd !== 5'd5 || out_data !== 32'hA5 || in_ready !== 1'b0)
         $display("FAIL stall_hold: got rd=%0d d=%h rdy=%0b, required 5 a5 0", out_rd, out_data, in_ready);
      else passes++;
      in_valid = 1'b0;
      out_ready = 1'b1;
      step();
      checks++;
      if (out_valid !== 1'b1 || out_rd !== 5'd6 || in_ready !== 1'b1)
         $display("FAIL stall_release: got v=%0b rd=%0d rdy=%0b, required 1 6 1", out_valid, out_rd, in_ready);
      else passes++;
      step();
      checks++;
      if (out_valid !== 1'b0) $display("FAIL stall_empty: got out_valid=%0b, required 0", out_valid);
      else passes++;
   endtask

   task automatic test_lookup();
      out_ready = 1'b0;
      set_alu(5'd7, 32'hAAAA);
      step();
      lookup_rd = 5'd7; #1;
      checks++;
      if (lookup_hit !== 1'b1 || lookup_data !== 32'hAAAA)
         $display("FAIL lookup_main: got hit=%0b d=%h, required 1 0000aaaa", lookup_hit, lookup_data);
      else passes++;
      set_alu(5'd7, 32'hBBBB);
      step();
      in_valid = 1'b0;
      lookup_rd = 5'd7; #1;
      checks++;
      if (lookup_hit !== 1'b1 || lookup_data !== 32'hBBBB)
         $display("FAIL lookup_skid: got hit=%0b d=%h, required 1 0000bbbb", lookup_hit, lookup_data);
      else passes++;
      lookup_rd = 5'd8; #1;
      checks++;
      if (lookup_hit !== 1'b0 || lookup_data !== 32'h0)
         $display("FAIL lookup_miss: got hit=%0b d=%h, required 0 0", lookup_hit, lookup_data);
      else passes++;
      out_ready = 1'b1;
      step();
      step();
      out_ready = 1'b0;
      set_alu(5'd0, 32'h1234);
      step();
      in_valid = 1'b0;
      lookup_rd = 5'd0; #1;
      checks++;
      if (out_valid !== 1'b1 || out_we !== 1'b0 || lookup_hit !== 1'b0)
         $display("FAIL zero_reg: got v=%0b we=%0b hit=%0b, required 1 0 0", out_valid, out_we, lookup_hit);
      else passes++;
      out_ready = 1'b1;
      step();
   endtask

   task automatic test_flush();
      out_ready = 1'b0;
      set_alu(5'd3, 32'h3333);
      step();
      set_alu(5'd4, 32'h4444);
      step();
      set_alu(5'd12, 32'hCCCC);
      flush = 1'b1;
      step();
      flush = 1'b0;
      in_valid = 1'b0;
      checks++;
      if (out_valid !== 1'b0 || in_ready !== 1'b1)
         $display("FAIL flush: got v=%0b rdy=%0b, required 0 1", out_valid, in_ready);
      else passes++;
      out_ready = 1'b1;
      for (int i = 0; i < 3; i++) step();
      checks++;
      if (out_valid !== 1'b0) $display("FAIL flush_stray: got out_valid=%0b, required 0", out_valid);
      else passes++;
   endtask

   task automatic test_async_reset();
      out_ready = 1'b0;
      set_alu(5'd14, 32'h5EED);
      step();
      in_valid = 1'b0;
      lookup_rd = 5'd14;
      #1;
      rst = 1'b1;
      #1;
      checks++;
      if ({out_valid, out_rd, out_we, out_data, in_ready, lookup_hit} !== {1'b0, 5'd0, 1'b0, 32'd0, 1'b1, 1'b0})
         $display("FAIL async_reset: got v=%0b rd=%0d we=%0b d=%h rdy=%0b hit=%0b, required 0 0 0 0 1 0",
                  out_valid, out_rd, out_we, out_data, in_ready, lookup_hit);
      else passes++;
      step();
      rst = 1'b0;
      out_ready = 1'b1;
      set_alu(5'd15, 32'hF00D);
      step();
      in_valid = 1'b0;
      step();
   endtask

   initial begin
      test_reset();
      test_back_to_back();
      test_load();
      test_stall();
      test_lookup();
      test_flush();
      test_async_reset();
      checks++;
      if (sb.size() != 0) $display("FAIL sb_leftover: got %0d pending entries, required 0", sb.size());
      else passes++;
      $display("%0d/%0d checks passed", passes, checks);
      $finish;
   end

endmodule
